encoder_input_conditioner: RTL and testbench
============================================

# encoder_input_conditioner

Front-end for the rotary-encoder speed control. Takes the raw asynchronous `sia`, `sib` and `sw` pins from the encoder board. Synchronises and debounces each pin, then decodes full-detent quadrature sequences into single-cycle clockwise and counter-clockwise step pulses, plus a push-switch press pulse. Sits directly upstream of `rotation_sensor`, which consumes these clean pulses to adjust and reset `clk_game`.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required before a pin change is accepted (1 ms at 100 MHz); must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

- `clk`  in  1: system clock, all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sia`  in  1: raw encoder channel A, asynchronous.
- `sib`  in  1: raw encoder channel B, asynchronous.
- `sw`  in  1: raw push switch, asynchronous, active-low (1 = released).
- `cw_pulse`  out  1: one-cycle pulse per completed clockwise detent (A leads B).
- `ccw_pulse`  out  1: one-cycle pulse per completed counter-clockwise detent (B leads A).
- `sw_press`  out  1: one-cycle pulse on debounced press (1→0).
- `sw_level`  out  1: debounced switch level, active-low.

## Operation
- Synchroniser: each pin passes through a 2-FF chain. Reset values: `sia`/`sib` chains 0, `sw` chain 1.
- Debouncer, per pin: holds a `deb` level and a counter.
  - Counter clears whenever synced == `deb`.
  - Otherwise the counter increments.
  - When it has differed for `DEBOUNCE_CYCLES` consecutive cycles, `deb` takes the synced value and the counter clears.
  - Any bounce back to `deb` before that restarts the count from 0.
  - Reset: `deb_a`=0, `deb_b`=0, `deb_sw`=1, counters 0.
- Quadrature FSM on {`deb_a`,`deb_b`}. States: IDLE(00), CW1(10), CW2(11), CW3(01), CCW1(01), CCW2(11), CCW3(10).
  - IDLE: 10→CW1; 01→CCW1.
  - CW1: 11→CW2; 00→IDLE.
  - CW2: 01→CW3; 10→CW1.
  - CW3: 00→IDLE and assert `cw_pulse`; 11→CW2.
  - CCW states: mirror image; CCW3→IDLE asserts `ccw_pulse`.
  - Unchanged input: stay in the current state.
  - Both bits change in the same cycle (both debouncers commit together): go to IDLE, no pulse.
  - Reversal mid-detent backs up along the path. No pulse until a full sequence ends at 00.
- `sw_press`: asserted for the cycle after `deb_sw` goes 1→0. `sw_level` = `deb_sw`.
- `cw_pulse` and `ccw_pulse` are never high in the same cycle.
- Switch and rotation paths are independent. Simultaneous press and detent completion produce both pulses.

## Timing
- Reset values: `cw_pulse`=0, `ccw_pulse`=0, `sw_press`=0, `sw_level`=1, FSM=IDLE.
- Latency, raw pin edge to `deb` update: 2 sync cycles + `DEBOUNCE_CYCLES` cycles (±1 for async sampling).
- Latency, `deb` update to pulse: 1 cycle (pulses registered).
- Every pulse is exactly 1 cycle wide. Minimum spacing between pulses is 2·`DEBOUNCE_CYCLES` cycles by construction.
- Reset mid-operation:
  - Pulses drop within the reset cycle.
  - A partially decoded detent is discarded.
  - Counters clear.
  - If the switch is held through reset, `sw_level` returns to 0 after a full debounce time, with a `sw_press` pulse.

## Structure
- Package `encoder_pkg`: quadrature state enum (`QS_IDLE`, `QS_CW1`…`QS_CCW3`), 2-bit phase constants `PH_00`/`PH_10`/`PH_11`/`PH_01`.
- Sub-module `debounce_bit`: parameters `DEBOUNCE_CYCLES` and `RESET_VAL`; contains the 2-FF synchroniser, counter and `deb` register. Instantiated three times.
- Top level holds the FSM, the `sw` edge detector and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset check: hold `rst` 3 cycles with all pins idle → all outputs 0, `sw_level`=1; no pulse for 50 cycles.
- CW detent: `sia`=1, +10 cycles `sib`=1, +40 `sia`=0, +10 `sib`=0 → exactly one `cw_pulse`, 7±1 cycles after the last edge; `ccw_pulse` stays 0.
- CCW detent: same pattern with `sib` leading `sia` → exactly one `ccw_pulse`. Four back-to-back CW detents → exactly four `cw_pulse`.
- Bounce rejection: toggle `sia` every 2 cycles for 20 cycles, then return to 0 → `deb_a` never changes, no pulses. Glitches of 3 cycles are rejected; 4+ stable cycles are accepted.
- Reversal/abort: 00→10→11→10→00 → no pulse, FSM back in IDLE. Force `sia`/`sib` to change together 00→11 → FSM IDLE, no pulse.
- Switch: `sw`=0 for 40 cycles, then 1 → one `sw_press`, `sw_level` low for ~40 cycles. Assert `rst` while in CW2 → no `cw_pulse` after the sequence finishes.

Source files
------------

// File: rtl/encoder_input_conditioner_pkg.sv
// Shared types and constants for the rotary-encoder input conditioner.
package encoder_pkg;

    // Quadrature decoder states; the CW and CCW paths each walk three
    // intermediate phases before a detent completes back at 00.
    typedef enum logic [2:0] {
        QS_IDLE = 3'd0,
        QS_CW1  = 3'd1,
        QS_CW2  = 3'd2,
        QS_CW3  = 3'd3,
        QS_CCW1 = 3'd4,
        QS_CCW2 = 3'd5,
        QS_CCW3 = 3'd6
    } qstate_t;

    // Debounced {a, b} phase values.
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

endpackage

// File: rtl/encoder_input_conditioner_debounce.sv
// Single-pin conditioner: 2-FF synchroniser followed by a stability counter.
// The debounced level only follows the synchronised pin once it has differed
// from the current level for DEBOUNCE_CYCLES consecutive cycles.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 100000,
    parameter logic RESET_VAL       = 1'b0,
    parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count consecutive differing cycles; commit on the last one, restart on any bounce back.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= RESET_VAL;
            cnt <= '0;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/encoder_input_conditioner.sv
// Rotary-encoder front-end: debounces A, B and the push switch, decodes full
// quadrature detents into registered single-cycle step pulses and turns the
// debounced switch falling edge into a single-cycle press pulse.
// fsm_state exposes the decoder state for observation.
module encoder_input_conditioner
    import encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    sia,
    input  logic    sib,
    input  logic    sw,
    output logic    cw_pulse,
    output logic    ccw_pulse,
    output logic    sw_press,
    output logic    sw_level,
    output qstate_t fsm_state
);

    logic       deb_a;
    logic       deb_b;
    logic       deb_sw;
    logic       deb_sw_q;
    logic [1:0] phase;
    logic [1:0] ph_q;
    qstate_t    state;

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0), .CNT_W(CNT_W))
        u_deb_a (.clk(clk), .rst(rst), .raw(sia), .deb(deb_a));

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0), .CNT_W(CNT_W))
        u_deb_b (.clk(clk), .rst(rst), .raw(sib), .deb(deb_b));

    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1), .CNT_W(CNT_W))
        u_deb_sw (.clk(clk), .rst(rst), .raw(sw), .deb(deb_sw));

    assign phase     = {deb_a, deb_b};
    assign sw_level  = deb_sw;
    assign fsm_state = state;

    // Quadrature decoder with registered step pulses; a double-bit phase jump is
    // ambiguous, so it aborts to IDLE without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= QS_IDLE;
            ph_q      <= PH_00;
            cw_pulse  <= 1'b0;
            ccw_pulse <= 1'b0;
        end else begin
            ph_q      <= phase;
            cw_pulse  <= 1'b0;
            ccw_pulse <= 1'b0;
            if ((phase ^ ph_q) == 2'b11) begin
                state <= QS_IDLE;
            end else begin
                case (state)
                    QS_IDLE: begin
                        if (phase == PH_10)      state <= QS_CW1;
                        else if (phase == PH_01) state <= QS_CCW1;
                    end
                    QS_CW1: begin
                        if (phase == PH_11)      state <= QS_CW2;
                        else if (phase == PH_00) state <= QS_IDLE;
                    end
                    QS_CW2: begin
                        if (phase == PH_01)      state <= QS_CW3;
                        else if (phase == PH_10) state <= QS_CW1;
                    end
                    QS_CW3: begin
                        if (phase == PH_00) begin
                            state    <= QS_IDLE;
                            cw_pulse <= 1'b1;
                        end else if (phase == PH_11) begin
                            state <= QS_CW2;
                        end
                    end
                    QS_CCW1: begin
                        if (phase == PH_11)      state <= QS_CCW2;
                        else if (phase == PH_00) state <= QS_IDLE;
                    end
                    QS_CCW2: begin
                        if (phase == PH_10)      state <= QS_CCW3;
                        else if (phase == PH_01) state <= QS_CCW1;
                    end
                    QS_CCW3: begin
                        if (phase == PH_00) begin
                            state     <= QS_IDLE;
                            ccw_pulse <= 1'b1;
                        end else if (phase == PH_11) begin
                            state <= QS_CCW2;
                        end
                    end
                    default: state <= QS_IDLE;
                endcase
            end
        end
    end

    // Press pulse on the debounced switch falling edge (switch is active-low).
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_sw_q <= 1'b1;
            sw_press <= 1'b0;
        end else begin
            deb_sw_q <= deb_sw;
            sw_press <= deb_sw_q & ~deb_sw;
        end
    end

endmodule

// File: tb/tb_encoder_input_conditioner.sv
// Directed bench for encoder_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_encoder_input_conditioner;
    import encoder_pkg::*;

    localparam int DEB = 4;

    logic    clk;
    logic    rst;
    logic    sia;
    logic    sib;
    logic    sw;
    logic    cw_pulse;
    logic    ccw_pulse;
    logic    sw_press;
    logic    sw_level;
    qstate_t fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running monitor totals; tests take differences across a window.
    int cyc         = 0;
    int cw_total    = 0;
    int ccw_total   = 0;
    int press_total = 0;
    int both_total  = 0;
    int cw_sw_total = 0;
    int non_idle    = 0;
    int cw1_total   = 0;
    int cw2_total   = 0;
    int low_total   = 0;
    int last_cw_cyc = 0;

    encoder_input_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .sia(sia), .sib(sib), .sw(sw),
        .cw_pulse(cw_pulse), .ccw_pulse(ccw_pulse),
        .sw_press(sw_press), .sw_level(sw_level), .fsm_state(fsm_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (cw_pulse) begin
                cw_total    = cw_total + 1;
                last_cw_cyc = cyc;
            end
            if (ccw_pulse) ccw_total = ccw_total + 1;
            if (sw_press) press_total = press_total + 1;
            if (cw_pulse && ccw_pulse) both_total = both_total + 1;
            if (cw_pulse && sw_press) cw_sw_total = cw_sw_total + 1;
            if (fsm_state != QS_IDLE) non_idle = non_idle + 1;
            if (fsm_state == QS_CW1) cw1_total = cw1_total + 1;
            if (fsm_state == QS_CW2) cw2_total = cw2_total + 1;
            if (!sw_level) low_total = low_total + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cw_detent();
        sia = 1'b1; tick(10);
        sib = 1'b1; tick(40);
        sia = 1'b0; tick(10);
        sib = 1'b0; tick(20);
    endtask

    task automatic ccw_detent();
        sib = 1'b1; tick(10);
        sia = 1'b1; tick(40);
        sib = 1'b0; tick(10);
        sia = 1'b0; tick(20);
    endtask

    task automatic test_reset();
        int c0, a0, p0;
        rst = 1'b1; sia = 1'b0; sib = 1'b0; sw = 1'b1;
        tick(3);
        n_checks++; if (cw_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_cw got %b want 0", cw_pulse); end
        n_checks++; if (ccw_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_ccw got %b want 0", ccw_pulse); end
        n_checks++; if (sw_press !== 1'b0) begin n_fail++; $display("FAIL reset_press got %b want 0", sw_press); end
        n_checks++; if (sw_level !== 1'b1) begin n_fail++; $display("FAIL reset_level got %b want 1", sw_level); end
        n_checks++; if (fsm_state !== QS_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want 0", fsm_state); end
        rst = 1'b0;
        c0 = cw_total; a0 = ccw_total; p0 = press_total;
        tick(50);
        n_checks++; if ((cw_total - c0) + (ccw_total - a0) + (press_total - p0) !== 0) begin
            n_fail++; $display("FAIL reset_quiet got %0d pulses want 0", (cw_total - c0) + (ccw_total - a0) + (press_total - p0));
        end
    endtask

    task automatic test_cw();
        int c0, a0, t0;
        c0 = cw_total; a0 = ccw_total;
        sia = 1'b1; tick(10);
        sib = 1'b1; tick(40);
        sia = 1'b0; tick(10);
        sib = 1'b0; t0 = cyc; tick(20);
        n_checks++; if (cw_total - c0 !== 1) begin n_fail++; $display("FAIL cw_count got %0d want 1", cw_total - c0); end
        n_checks++; if (ccw_total - a0 !== 0) begin n_fail++; $display("FAIL cw_no_ccw got %0d want 0", ccw_total - a0); end
        n_checks++; if ((last_cw_cyc - t0) < 6 || (last_cw_cyc - t0) > 8) begin
            n_fail++; $display("FAIL cw_latency got %0d want 7+-1", last_cw_cyc - t0);
        end
        n_checks++; if (fsm_state !== QS_IDLE) begin n_fail++; $display("FAIL cw_end_state got %0d want 0", fsm_state); end
    endtask

    task automatic test_ccw();
        int c0, a0;
        c0 = cw_total; a0 = ccw_total;
        ccw_detent();
        n_checks++; if (ccw_total - a0 !== 1) begin n_fail++; $display("FAIL ccw_count got %0d want 1", ccw_total - a0); end
        n_checks++; if (cw_total - c0 !== 0) begin n_fail++; $display("FAIL ccw_no_cw got %0d want 0", cw_total - c0); end
    endtask

    task automatic test_back_to_back();
        int c0, a0;
        c0 = cw_total; a0 = ccw_total;
        for (int i = 0; i < 4; i++) cw_detent();
        n_checks++; if (cw_total - c0 !== 4) begin n_fail++; $display("FAIL b2b_cw_count got %0d want 4", cw_total - c0); end
        n_checks++; if (ccw_total - a0 !== 0) begin n_fail++; $display("FAIL b2b_ccw_count got %0d want 0", ccw_total - a0); end
    endtask

    task automatic test_bounce();
        int n0, c0, a0, w0;
        n0 = non_idle; c0 = cw_total; a0 = ccw_total;
        for (int i = 0; i < 10; i++) begin
            sia = ~sia; tick(2);
        end
        sia = 1'b0; tick(20);
        n_checks++; if (non_idle - n0 !== 0) begin n_fail++; $display("FAIL bounce_fast got %0d busy cycles want 0", non_idle - n0); end
        n0 = non_idle;
        sia = 1'b1; tick(3);
        sia = 1'b0; tick(15);
        n_checks++; if (non_idle - n0 !== 0) begin n_fail++; $display("FAIL glitch3 got %0d busy cycles want 0", non_idle - n0); end
        w0 = cw1_total;
        sia = 1'b1; tick(4);
        sia = 1'b0; tick(20);
        n_checks++; if ((cw1_total - w0 > 0) !== 1'b1) begin n_fail++; $display("FAIL stable4 got %0d cw1 cycles want >0", cw1_total - w0); end
        n_checks++; if (fsm_state !== QS_IDLE) begin n_fail++; $display("FAIL stable4_state got %0d want 0", fsm_state); end
        n_checks++; if ((cw_total - c0) + (ccw_total - a0) !== 0) begin
            n_fail++; $display("FAIL bounce_pulses got %0d want 0", (cw_total - c0) + (ccw_total - a0));
        end
    endtask

    task automatic test_reversal();
        int c0, a0, w0;
        c0 = cw_total; a0 = ccw_total; w0 = cw2_total;
        sia = 1'b1; tick(10);
        sib = 1'b1; tick(10);
        sib = 1'b0; tick(10);
        sia = 1'b0; tick(20);
        n_checks++; if ((cw2_total - w0 > 0) !== 1'b1) begin n_fail++; $display("FAIL rev_reached_cw2 got %0d want >0", cw2_total - w0); end
        n_checks++; if (fsm_state !== QS_IDLE) begin n_fail++; $display("FAIL rev_state got %0d want 0", fsm_state); end
        n_checks++; if ((cw_total - c0) + (ccw_total - a0) !== 0) begin
            n_fail++; $display("FAIL rev_pulses got %0d want 0", (cw_total - c0) + (ccw_total - a0));
        end
    endtask

    task automatic test_both_change();
        int n0, c0, a0;
        n0 = non_idle; c0 = cw_total; a0 = ccw_total;
        sia = 1'b1; sib = 1'b1; tick(15);
        n_checks++; if (fsm_state !== QS_IDLE) begin n_fail++; $display("FAIL both_up_state got %0d want 0", fsm_state); end
        sia = 1'b0; sib = 1'b0; tick(15);
        n_checks++; if (non_idle - n0 !== 0) begin n_fail++; $display("FAIL both_busy got %0d want 0", non_idle - n0); end
        n_checks++; if ((cw_total - c0) + (ccw_total - a0) !== 0) begin
            n_fail++; $display("FAIL both_pulses got %0d want 0", (cw_total - c0) + (ccw_total - a0));
        end
    endtask

    task automatic test_switch();
        int p0, l0;
        p0 = press_total; l0 = low_total;
        sw = 1'b0; tick(40);
        sw = 1'b1; tick(20);
        n_checks++; if (press_total - p0 !== 1) begin n_fail++; $display("FAIL sw_press_count got %0d want 1", press_total - p0); end
        n_checks++; if ((low_total - l0) < 39 || (low_total - l0) > 41) begin
            n_fail++; $display("FAIL sw_low_time got %0d want 40+-1", low_total - l0);
        end
        n_checks++; if (sw_level !== 1'b1) begin n_fail++; $display("FAIL sw_release_level got %b want 1", sw_level); end
    endtask

    task automatic test_reset_mid_detent();
        int c0, a0;
        sia = 1'b1; tick(10);
        sib = 1'b1; tick(10);
        n_checks++; if (fsm_state !== QS_CW2) begin n_fail++; $display("FAIL mid_in_cw2 got %0d want 2", fsm_state); end
        rst = 1'b1; tick(1);
        n_checks++; if (fsm_state !== QS_IDLE) begin n_fail++; $display("FAIL mid_rst_state got %0d want 0", fsm_state); end
        rst = 1'b0;
        c0 = cw_total; a0 = ccw_total;
        tick(10);
        sia = 1'b0; tick(10);
        sib = 1'b0; tick(20);
        n_checks++; if (cw_total - c0 !== 0) begin n_fail++; $display("FAIL mid_no_cw got %0d want 0", cw_total - c0); end
        n_checks++; if (ccw_total - a0 !== 0) begin n_fail++; $display("FAIL mid_no_ccw got %0d want 0", ccw_total - a0); end
    endtask

    task automatic test_sw_held_reset();
        int p0;
        sw = 1'b0; tick(20);
        rst = 1'b1; tick(2);
        rst = 1'b0;
        n_checks++; if (sw_level !== 1'b1) begin n_fail++; $display("FAIL held_rst_level got %b want 1", sw_level); end
        p0 = press_total;
        tick(15);
        n_checks++; if (sw_level !== 1'b0) begin n_fail++; $display("FAIL held_relevel got %b want 0", sw_level); end
        n_checks++; if (press_total - p0 !== 1) begin n_fail++; $display("FAIL held_press got %0d want 1", press_total - p0); end
        sw = 1'b1; tick(15);
    endtask

    task automatic test_simultaneous();
        int s0;
        s0 = cw_sw_total;
        sia = 1'b1; tick(10);
        sib = 1'b1; tick(40);
        sia = 1'b0; tick(10);
        sib = 1'b0; sw = 1'b0; tick(20);
        sw = 1'b1; tick(15);
        n_checks++; if (cw_sw_total - s0 !== 1) begin n_fail++; $display("FAIL simul_cw_press got %0d want 1", cw_sw_total - s0); end
    endtask

    initial begin
        rst = 1'b1; sia = 1'b0; sib = 1'b0; sw = 1'b1;
        test_reset();
        test_cw();
        test_ccw();
        test_back_to_back();
        test_bounce();
        test_reversal();
        test_both_change();
        test_switch();
        test_reset_mid_detent();
        test_sw_held_reset();
        test_simultaneous();
        n_checks++; if (both_total !== 0) begin n_fail++; $display("FAIL cw_ccw_overlap got %0d want 0", both_total); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
